y86_mem_arbiter: RTL and testbench

Arbitrates the single-ported unified instruction/data memory of the Y86 pipelined processor between the fetch stage and the memory stage.
- Fetch reads are 2 beats (10 instruction bytes); data accesses are 1 beat.
- Returns responses with a status code and exports stall requests that the pipeline control logic ORs into F_stall, D_stall and the M-stage hold.
- Non-preemptive; memory stage has priority at grant points; per-beat ack timeout.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/mem_beat_timer.sv | 28 ++
 rtl/y86_mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_y86_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status codes, arbiter state encoding, bus widths.
package y86_pkg;

    localparam int unsigned ADDR_W      = 64;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned INSTR_BYTES = 10;
    localparam int unsigned INSTR_W     = INSTR_BYTES * 8;
    localparam int unsigned STAT_W      = 2;

    typedef enum logic [STAT_W-1:0] {
        STAT_AOK = 2'b00,
        STAT_HLT = 2'b01,
        STAT_ADR = 2'b10,
        STAT_INS = 2'b11
    } stat_e;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_DATA   = 3'd1,
        ARB_FBEAT0 = 3'd2,
        ARB_FBEAT1 = 3'd3,
        ARB_RESP   = 3'd4
    } arb_state_e;

    // True when addr..addr+last_off lies inside memory; 65-bit sum so wrap-around fails the check.
    function automatic logic range_ok(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       last_off,
                                      input int unsigned       mem_bytes);
        logic [ADDR_W:0] last;
        last = {1'b0, addr} + (ADDR_W+1)'(last_off);
        return last < (ADDR_W+1)'(mem_bytes);
    endfunction

endpackage

// File: rtl/mem_beat_timer.sv
// Per-beat ack timeout counter: clears between beats, flags expiry on the last waiting cycle.
module mem_beat_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic run_i,
    output logic expired_c_o
);

    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] cnt_q;

    // Expiry fires on the cycle whose missing ack would bring the count to TIMEOUT.
    assign expired_c_o = run_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Count cycles a beat is outstanding without ack.
    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            cnt_q <= '0;
        end else if (run_i && !expired_c_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/y86_mem_arbiter.sv
// Single-port memory arbiter between Y86 fetch (2-beat) and memory stage (1-beat).
module y86_mem_arbiter
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               f_req,
    input  logic [ADDR_W-1:0]  f_addr,
    input  logic               m_req,
    input  logic               m_we,
    input  logic [ADDR_W-1:0]  m_addr,
    input  logic [DATA_W-1:0]  m_wdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic               f_done,
    output logic [INSTR_W-1:0] f_bytes,
    output logic [STAT_W-1:0]  f_stat,
    output logic               m_done,
    output logic [DATA_W-1:0]  m_rdata,
    output logic [STAT_W-1:0]  m_stat,
    output logic               f_stall,
    output logic               m_stall
);

    arb_state_e         state_q;
    logic               own_fetch_q;
    logic               cancel_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [DATA_W-1:0]  buf_q;
    logic               f_done_q;
    logic [INSTR_W-1:0] f_bytes_q;
    logic [STAT_W-1:0]  f_stat_q;
    logic               m_done_q;
    logic [DATA_W-1:0]  m_rdata_q;
    logic [STAT_W-1:0]  m_stat_q;

    logic grant_m_c;
    logic grant_f_c;
    logic m_ok_c;
    logic f_ok_c;
    logic owner_req_c;
    logic deliver_c;
    logic expired_c;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign f_done    = f_done_q;
    assign f_bytes   = f_bytes_q;
    assign f_stat    = f_stat_q;
    assign m_done    = m_done_q;
    assign m_rdata   = m_rdata_q;
    assign m_stat    = m_stat_q;
    assign f_stall   = f_req & ~f_done_q;
    assign m_stall   = m_req & ~m_done_q;

    assign m_ok_c      = range_ok(m_addr, 7, MEM_BYTES);
    assign f_ok_c      = range_ok(f_addr, INSTR_BYTES - 1, MEM_BYTES);
    assign owner_req_c = own_fetch_q ? f_req : m_req;
    // A request that dropped at any point during its access gets no response.
    assign deliver_c   = ~cancel_q & owner_req_c;

    // Grant points: IDLE (data first) and RESP, where only the port not being answered may win,
    // because the answered port's request is still the stale one it is about to drop.
    always_comb begin
        grant_m_c = 1'b0;
        grant_f_c = 1'b0;
        if (state_q == ARB_IDLE) begin
            grant_m_c = m_req;
            grant_f_c = f_req & ~m_req;
        end else if (state_q == ARB_RESP) begin
            grant_m_c = m_req & own_fetch_q;
            grant_f_c = f_req & ~own_fetch_q;
        end
    end

    mem_beat_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i       (clk),
        .reset_i     (reset),
        .clr_i       (~mem_req_q | mem_ack),
        .run_i       (mem_req_q & ~mem_ack),
        .expired_c_o (expired_c)
    );

    // Arbiter FSM with registered memory-side and response-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            own_fetch_q <= 1'b0;
            cancel_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            buf_q       <= '0;
            f_done_q    <= 1'b0;
            f_bytes_q   <= '0;
            f_stat_q    <= '0;
            m_done_q    <= 1'b0;
            m_rdata_q   <= '0;
            m_stat_q    <= '0;
        end else begin
            f_done_q <= 1'b0;
            m_done_q <= 1'b0;
            if (mem_req_q && !owner_req_c) begin
                cancel_q <= 1'b1;
            end
            unique case (state_q)
                ARB_IDLE, ARB_RESP: begin
                    state_q <= ARB_IDLE;
                    if (grant_m_c) begin
                        own_fetch_q <= 1'b0;
                        cancel_q    <= 1'b0;
                        if (m_ok_c) begin
                            state_q     <= ARB_DATA;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= m_we;
                            mem_addr_q  <= m_addr;
                            mem_wdata_q <= m_wdata;
                        end else begin
                            state_q  <= ARB_RESP;
                            m_done_q <= 1'b1;
                            m_stat_q <= STAT_ADR;
                        end
                    end else if (grant_f_c) begin
                        own_fetch_q <= 1'b1;
                        cancel_q    <= 1'b0;
                        if (f_ok_c) begin
                            state_q    <= ARB_FBEAT0;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= f_addr;
                        end else begin
                            state_q  <= ARB_RESP;
                            f_done_q <= 1'b1;
                            f_stat_q <= STAT_ADR;
                        end
                    end
                end
                ARB_DATA: begin
                    if (mem_ack) begin
                        state_q   <= ARB_RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (deliver_c) begin
                            m_done_q <= 1'b1;
                            m_stat_q <= STAT_AOK;
                            if (!mem_we_q) begin
                                m_rdata_q <= mem_rdata;
                            end
                        end
                    end else if (expired_c) begin
                        state_q   <= ARB_RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (deliver_c) begin
                            m_done_q <= 1'b1;
                            m_stat_q <= STAT_ADR;
                        end
                    end
                end
                ARB_FBEAT0: begin
                    if (mem_ack) begin
                        state_q    <= ARB_FBEAT1;
                        buf_q      <= mem_rdata;
                        mem_addr_q <= mem_addr_q + ADDR_W'(8);
                    end else if (expired_c) begin
                        state_q   <= ARB_RESP;
                        mem_req_q <= 1'b0;
                        if (deliver_c) begin
                            f_done_q <= 1'b1;
                            f_stat_q <= STAT_ADR;
                        end
                    end
                end
                ARB_FBEAT1: begin
                    if (mem_ack) begin
                        state_q   <= ARB_RESP;
                        mem_req_q <= 1'b0;
                        if (deliver_c) begin
                            f_done_q  <= 1'b1;
                            f_bytes_q <= {mem_rdata[15:0], buf_q};
                            f_stat_q  <= STAT_AOK;
                        end
                    end else if (expired_c) begin
                        state_q   <= ARB_RESP;
                        mem_req_q <= 1'b0;
                        if (deliver_c) begin
                            f_done_q <= 1'b1;
                            f_stat_q <= STAT_ADR;
                        end
                    end
                end
                default: begin
                    state_q   <= ARB_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Scoreboard bench for y86_mem_arbiter with a behavioural byte memory.
module tb_y86_mem_arbiter;

    localparam int unsigned MEM_BYTES = 4096;
    localparam int          LAT_MAX   = 64;
    localparam logic [1:0]  AOK       = 2'b00;
    localparam logic [1:0]  ADR       = 2'b10;

    typedef struct {
        logic [79:0] data;
        logic [1:0]  stat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [63:0] f_addr;
    logic        m_req;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        f_done;
    logic [79:0] f_bytes;
    logic [1:0]  f_stat;
    logic        m_done;
    logic [63:0] m_rdata;
    logic [1:0]  m_stat;
    logic        f_stall;
    logic        m_stall;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        f_q[$];
    exp_t        m_q[$];
    exp_t        mon_e;
    logic [79:0] f_model = '0;
    logic [63:0] m_model = '0;

    logic [7:0]  slv_mem [MEM_BYTES];
    logic [7:0]  shadow  [MEM_BYTES];
    bit          slv_init = 1'b0;
    int          ack_mode = 0;
    bit          ack_now = 1'b1;

    always #5 clk = ~clk;

    y86_mem_arbiter #(
        .MEM_BYTES (MEM_BYTES),
        .TIMEOUT   (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .f_done    (f_done),
        .f_bytes   (f_bytes),
        .f_stat    (f_stat),
        .m_done    (m_done),
        .m_rdata   (m_rdata),
        .m_stat    (m_stat),
        .f_stall   (f_stall),
        .m_stall   (m_stall)
    );

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            32'h20: return 8'h30;
            32'h21: return 8'hF2;
            32'h22: return 8'h05;
            32'h23, 32'h24, 32'h25, 32'h26, 32'h27, 32'h28, 32'h29: return 8'h00;
            default: return 8'((i * 7 + 3) | 1);
        endcase
    endfunction

    function automatic logic [63:0] slv_rd64(input logic [63:0] a);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (a + 64'(i) < 64'(MEM_BYTES)) r[8*i +: 8] = slv_mem[32'(a) + i];
        end
        return r;
    endfunction

    function automatic bit in_range(input logic [63:0] a, input int last);
        logic [64:0] e;
        e = {1'b0, a} + 65'(last);
        return e <= 65'(MEM_BYTES - 1);
    endfunction

    // Memory slave: combinational read, write on acked beat.
    always_comb mem_rdata = slv_rd64(mem_addr);
    assign mem_ack = mem_req & ack_now;

    always @(posedge clk) begin
        if (!slv_init) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) slv_mem[i] = init_byte(i);
            slv_init = 1'b1;
        end else if (mem_req && mem_we && mem_ack) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_addr + 64'(i) < 64'(MEM_BYTES)) slv_mem[32'(mem_addr) + i] = mem_wdata[8*i +: 8];
            end
        end
    end

    always @(negedge clk) begin
        case (ack_mode)
            0:       ack_now = 1'b1;
            1:       ack_now = 1'b0;
            default: ack_now = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response monitor: every done pulse must match the oldest expectation for its port.
    always @(negedge clk) begin
        if (!reset) begin
            if (f_done) begin
                if (f_q.size() == 0) check("f_spurious_done", 1, 0);
                else begin
                    mon_e = f_q.pop_front();
                    check("f_bytes", f_bytes, mon_e.data);
                    check("f_stat", 80'(f_stat), 80'(mon_e.stat));
                end
            end
            if (m_done) begin
                if (m_q.size() == 0) check("m_spurious_done", 1, 0);
                else begin
                    mon_e = m_q.pop_front();
                    check("m_rdata", 80'(m_rdata), mon_e.data);
                    check("m_stat", 80'(m_stat), 80'(mon_e.stat));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic data_req(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                            input bit exp_to, output int lat, output int req_cyc);
        exp_t e;
        if (in_range(addr, 7) && !exp_to) begin
            if (we) begin
                for (int i = 0; i < 8; i++) shadow[32'(addr) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < 8; i++) m_model[8*i +: 8] = shadow[32'(addr) + i];
            end
            e.stat = AOK;
        end else begin
            e.stat = ADR;
        end
        e.data = 80'(m_model);
        m_q.push_back(e);
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd;
        lat = 0; req_cyc = 0;
        do begin
            @(posedge clk); #1; lat++;
            if (mem_req) req_cyc++;
            if (lat == 1 && !m_done) check("m_stall", 80'(m_stall), 1);
        end while (!m_done && lat < LAT_MAX);
        if (!m_done) check("m_done_timeout", 0, 1);
        m_req = 1'b0;
    endtask

    task automatic fetch_req(input logic [63:0] addr, output int lat);
        exp_t e;
        if (in_range(addr, 9)) begin
            for (int i = 0; i < 10; i++) f_model[8*i +: 8] = shadow[32'(addr) + i];
            e.stat = AOK;
        end else begin
            e.stat = ADR;
        end
        e.data = f_model;
        f_q.push_back(e);
        f_req = 1'b1; f_addr = addr;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
            if (lat == 1 && !f_done) check("f_stall", 80'(f_stall), 1);
        end while (!f_done && lat < LAT_MAX);
        if (!f_done) check("f_done_timeout", 0, 1);
        f_req = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat_f, lat_m, rc;
        logic [63:0] a, wd;

        for (int i = 0; i < int'(MEM_BYTES); i++) shadow[i] = init_byte(i);
        reset = 1'b1; f_req = 1'b0; f_addr = '0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 80'(mem_req), 0);
        check("rst_mem_addr", 80'(mem_addr), 0);
        check("rst_f_done", 80'(f_done), 0);
        check("rst_m_done", 80'(m_done), 0);
        check("rst_f_bytes", f_bytes, 0);
        check("rst_m_rdata", 80'(m_rdata), 0);
        reset = 1'b0;
        idle(2);

        // Fetch only
        fetch_req(64'h20, lat_f);
        check("fetch_lat", 80'(lat_f), 3);
        check("fetch_lo", 80'(f_bytes[23:0]), 80'h05F230);
        check("fetch_stat", 80'(f_stat), 0);

        // Simultaneous: data write first, fetch follows
        idle(1);
        fork
            data_req(1'b1, 64'h100, 64'hDEAD, 1'b0, lat_m, rc);
            fetch_req(64'h80, lat_f);
        join
        check("both_m_lat", 80'(lat_m), 2);
        check("both_f_lat", 80'(lat_f), 5);
        check("mem_100", 80'(slv_rd64(64'h100)), 80'hDEAD);
        idle(1);
        data_req(1'b0, 64'h100, '0, 1'b0, lat_m, rc);
        check("rd_lat", 80'(lat_m), 2);

        // Address errors and boundaries
        idle(1);
        data_req(1'b0, 64'(MEM_BYTES - 4), '0, 1'b0, lat_m, rc);
        check("m_adr_lat", 80'(lat_m), 1);
        check("m_adr_no_beat", 80'(rc), 0);
        idle(1);
        data_req(1'b0, 64'(MEM_BYTES - 8), '0, 1'b0, lat_m, rc);
        idle(1);
        fetch_req(64'(MEM_BYTES - 10), lat_f);
        check("f_edge_lat", 80'(lat_f), 3);
        idle(1);
        fetch_req(64'(MEM_BYTES - 9), lat_f);
        check("f_adr_lat", 80'(lat_f), 1);
        idle(1);
        data_req(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, '0, 1'b0, lat_m, rc);
        check("m_ovf_lat", 80'(lat_m), 1);

        // Ack timeout then normal service
        ack_mode = 1;
        idle(1);
        data_req(1'b0, 64'h300, '0, 1'b1, lat_m, rc);
        check("to_req_cycles", 80'(rc), 15);
        check("to_lat", 80'(lat_m), 16);
        ack_mode = 0;
        idle(1);
        fetch_req(64'h20, lat_f);
        check("after_to_lat", 80'(lat_f), 3);

        // Fetch dropped in FBEAT1, pending data granted right after
        idle(1);
        f_req = 1'b1; f_addr = 64'h40;
        idle(2);
        check("cancel_beat1_req", 80'(mem_req), 1);
        check("cancel_beat1_addr", 80'(mem_addr), 80'h48);
        f_req = 1'b0;
        data_req(1'b0, 64'h200, '0, 1'b0, lat_m, rc);
        check("cancel_m_lat", 80'(lat_m), 3);

        // Reset during FBEAT0
        idle(1);
        f_req = 1'b1; f_addr = 64'h60;
        idle(1);
        check("fb0_mem_req", 80'(mem_req), 1);
        reset = 1'b1;
        idle(1);
        check("rst2_mem_req", 80'(mem_req), 0);
        check("rst2_mem_addr", 80'(mem_addr), 0);
        check("rst2_f_done", 80'(f_done), 0);
        check("rst2_f_bytes", f_bytes, 0);
        check("rst2_m_rdata", 80'(m_rdata), 0);
        check("rst2_f_stat", 80'(f_stat), 0);
        f_req = 1'b0; reset = 1'b0;
        f_model = '0; m_model = '0;
        idle(3);

        // Random traffic with random ack delays
        ack_mode = 2;
        for (int k = 0; k < 8; k++) begin
            a  = 64'(32'h400 + $urandom_range(0, 1000));
            wd = {$urandom, $urandom};
            data_req(1'b1, a, wd, 1'b0, lat_m, rc);
            data_req(1'b0, a, '0, 1'b0, lat_m, rc);
            fetch_req(64'(32'h400 + $urandom_range(0, 1000)), lat_f);
        end
        ack_mode = 0;
        idle(4);

        check("f_q_empty", 80'(f_q.size()), 0);
        check("m_q_empty", 80'(m_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
